// File: rtl/tea_serial_bridge_if.sv
// Valid/ready stream port pair for tea_serial_bridge: beat input with job mode, beat output.
// iMode widens to {keep key, direction} when TEA_KEY_RETAIN_EN is defined.
interface tea_serial_bridge_if #(
    parameter int PORT_WIDTH = 8
);
`ifdef TEA_KEY_RETAIN_EN
    localparam int MODE_W = 2;
`else
    localparam int MODE_W = 1;
`endif

    logic [PORT_WIDTH-1:0] iData;
    logic                  iValid;
    logic [MODE_W-1:0]     iMode;
    logic                  oReady;
    logic [PORT_WIDTH-1:0] oData;
    logic                  oValid;
    logic                  iReady;

    modport slave (
        input  iData, iValid, iMode, iReady,
        output oReady, oData, oValid
    );

    modport master (
        output iData, iValid, iMode, iReady,
        input  oReady, oData, oValid
    );
endinterface

// File: rtl/tea_serial_bridge.sv
// Serial front end for the TEA core: loads V0,V1,K0..K3 in PORT_WIDTH beats, pulses start,
// streams the two result words back out. TEA_KEY_RETAIN_EN adds a keep-key short load.
module tea_serial_bridge #(
    parameter int          WORD_SIZE    = 32,
    parameter int          PORT_WIDTH   = 8,
    parameter logic [31:0] DELTA        = 32'h9e3779b9,
    parameter int          ROUND_NUMBER = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tea_serial_bridge_if.slave   bus,
    output logic [WORD_SIZE-1:0] oV0,
    output logic [WORD_SIZE-1:0] oV1,
    output logic [WORD_SIZE-1:0] oK0,
    output logic [WORD_SIZE-1:0] oK1,
    output logic [WORD_SIZE-1:0] oK2,
    output logic [WORD_SIZE-1:0] oK3,
    output logic                 oStartCipher,
    output logic                 oStartDecipher,
    output logic                 oBusy,
    input  logic [WORD_SIZE-1:0] iC0,
    input  logic [WORD_SIZE-1:0] iC1,
    input  logic [WORD_SIZE-1:0] iV0,
    input  logic [WORD_SIZE-1:0] iV1,
    input  logic                 iDoneCipher,
    input  logic                 iDoneDecipher
);
    localparam int W  = WORD_SIZE;
    localparam int P  = PORT_WIDTH;
    localparam int S  = W / P;
    localparam int L  = 6 * S;
    localparam int U  = 2 * S;
    localparam int CW = $clog2(L);

    localparam logic [CW-1:0] LAST_FULL  = CW'(L - 1);
    localparam logic [CW-1:0] LAST_VONLY = CW'(2 * S - 1);
    localparam logic [CW-1:0] LAST_OUT   = CW'(U - 1);
    localparam logic [CW-1:0] V_BEATS    = CW'(2 * S);

    // DELTA and ROUND_NUMBER belong to the core; only sanity-checked here.
    if ((W % P != 0) || (ROUND_NUMBER < 1) || (DELTA == 32'h0)) begin : gBadCfg
        $error("tea_serial_bridge: WORD_SIZE must be a multiple of PORT_WIDTH");
    end

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, UNLOAD} state_t;

    state_t          state, stateNxt;
    logic [CW-1:0]   cnt;
    logic            mode;
    logic            keep;
    logic [2*W-1:0]  vSr;
    logic [4*W-1:0]  kSr;
    logic [2*W-1:0]  outSr;
    logic            accept;
    logic            doneHit;
    logic [CW-1:0]   lastLoad;

    assign accept   = bus.iValid && bus.oReady;
    assign doneHit  = mode ? iDoneDecipher : iDoneCipher;
    assign lastLoad = keep ? LAST_VONLY : LAST_FULL;

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:    if (accept) stateNxt = LOAD;
            LOAD:    if (accept && cnt == lastLoad) stateNxt = START;
            START:   stateNxt = WAIT;
            WAIT:    if (doneHit) stateNxt = UNLOAD;
            UNLOAD:  if (bus.iReady && cnt == LAST_OUT) stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            mode  <= 1'b0;
            keep  <= 1'b0;
            vSr   <= '0;
            kSr   <= '0;
            outSr <= '0;
        end else begin
            state <= stateNxt;
            if (state == IDLE && accept) begin
                mode <= bus.iMode[0];
`ifdef TEA_KEY_RETAIN_EN
                keep <= bus.iMode[1];
`else
                keep <= 1'b0;
`endif
            end
            // V words come first on the wire; everything after them is key material.
            if (accept) begin
                if (cnt < V_BEATS) vSr <= {vSr[2*W-P-1:0], bus.iData};
                else               kSr <= {kSr[4*W-P-1:0], bus.iData};
                cnt <= (state == LOAD && cnt == lastLoad) ? '0 : cnt + 1'b1;
            end
            if (state == WAIT && doneHit)
                outSr <= mode ? {iV0, iV1} : {iC0, iC1};
            if (state == UNLOAD && bus.iReady) begin
                outSr <= outSr << P;
                cnt   <= (cnt == LAST_OUT) ? '0 : cnt + 1'b1;
            end
        end
    end

    assign bus.oReady     = (state == IDLE) || (state == LOAD);
    assign bus.oValid     = (state == UNLOAD);
    assign bus.oData      = (state == UNLOAD) ? outSr[2*W-1 -: P] : '0;
    assign oBusy          = (state != IDLE);
    assign oStartCipher   = (state == START) && !mode;
    assign oStartDecipher = (state == START) && mode;

    assign oV0 = vSr[2*W-1 -: W];
    assign oV1 = vSr[W-1:0];
    assign oK0 = kSr[4*W-1 -: W];
    assign oK1 = kSr[3*W-1 -: W];
    assign oK2 = kSr[2*W-1 -: W];
    assign oK3 = kSr[W-1:0];
endmodule

// File: tb/tb_tea_serial_bridge.sv
// Directed bench for tea_serial_bridge: 8-bit and 32-bit instances, core results driven as
// known-answer constants (TEA of zero block under zero key = 41EA3A0A 94BAA940).
module tb_tea_serial_bridge;
`ifdef TEA_KEY_RETAIN_EN
    localparam int MODE_W = 2;
`else
    localparam int MODE_W = 1;
`endif
    localparam logic [63:0] KAT = 64'h41EA3A0A_94BAA940;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tea_serial_bridge_if #(.PORT_WIDTH(8))  b8();
    tea_serial_bridge_if #(.PORT_WIDTH(32)) b32();

    logic [31:0] v0a, v1a, k0a, k1a, k2a, k3a, v0b, v1b, k0b, k1b, k2b, k3b;
    logic        startCa, startDa, busyA, doneCa, doneDa;
    logic        startCb, startDb, busyB, doneCb, doneDb;
    logic [31:0] c0, c1, pv0, pv1;

    tea_serial_bridge #(.WORD_SIZE(32), .PORT_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(b8.slave),
        .oV0(v0a), .oV1(v1a), .oK0(k0a), .oK1(k1a), .oK2(k2a), .oK3(k3a),
        .oStartCipher(startCa), .oStartDecipher(startDa), .oBusy(busyA),
        .iC0(c0), .iC1(c1), .iV0(pv0), .iV1(pv1),
        .iDoneCipher(doneCa), .iDoneDecipher(doneDa)
    );

    tea_serial_bridge #(.WORD_SIZE(32), .PORT_WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .bus(b32.slave),
        .oV0(v0b), .oV1(v1b), .oK0(k0b), .oK1(k1b), .oK2(k2b), .oK3(k3b),
        .oStartCipher(startCb), .oStartDecipher(startDb), .oBusy(busyB),
        .iC0(c0), .iC1(c1), .iV0(pv0), .iV1(pv1),
        .iDoneCipher(doneCb), .iDoneDecipher(doneDb)
    );

    int errors = 0;
    int checks = 0;
    int nStartC = 0;
    int nStartD = 0;
    int baseC, baseD;

    always @(posedge clk) begin
        if (startCa) nStartC++;
        if (startDa) nStartD++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load8(input logic [191:0] vec, input int n, input logic [1:0] m);
        for (int i = 0; i < n; i++) begin
            b8.iData  = vec[191-8*i -: 8];
            b8.iValid = 1'b1;
            b8.iMode  = m[MODE_W-1:0];
            chk("load_ready", b8.oReady, 1);
            @(negedge clk);
        end
        b8.iValid = 1'b0;
        b8.iData  = 8'h5A;
    endtask

    task automatic unload8(input logic [63:0] exp, input logic [15:0] pat);
        int got = 0;
        int guard = 0;
        while (got < 8 && guard < 100) begin
            guard++;
            b8.iReady = pat[guard % 16];
            chk("unl_valid", b8.oValid, 1);
            chk("unl_data", b8.oData, exp[63-8*got -: 8]);
            chk("unl_ready", b8.oReady, 0);
            @(negedge clk);
            if (b8.iReady) got++;
        end
        b8.iReady = 1'b0;
        chk("unl_count", got, 8);
        chk("post_valid", b8.oValid, 0);
        chk("post_ready", b8.oReady, 1);
        chk("post_busy", busyA, 0);
    endtask

    // Done is pulsed during START (must be ignored), then the wrong flag in WAIT, then the right one.
    task automatic finish8(input logic dir);
        if (dir) doneDa = 1'b1; else doneCa = 1'b1;
        @(negedge clk);
        doneCa = 1'b0; doneDa = 1'b0;
        chk("wait_no_start", {startCa, startDa}, 2'b00);
        chk("wait_valid0", b8.oValid, 0);
        if (dir) doneCa = 1'b1; else doneDa = 1'b1;
        @(negedge clk);
        doneCa = 1'b0; doneDa = 1'b0;
        chk("wrong_done_ignored", b8.oValid, 0);
        chk("wait_busy", busyA, 1);
        if (dir) doneDa = 1'b1; else doneCa = 1'b1;
        @(negedge clk);
        doneCa = 1'b0; doneDa = 1'b0;
        chk("done_to_valid", b8.oValid, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        b8.iData = '0;  b8.iValid = 1'b0;  b8.iMode = '0;  b8.iReady = 1'b0;
        b32.iData = '0; b32.iValid = 1'b0; b32.iMode = '0; b32.iReady = 1'b0;
        doneCa = 0; doneDa = 0; doneCb = 0; doneDb = 0;
        c0 = KAT[63:32]; c1 = KAT[31:0]; pv0 = '0; pv1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", b8.oReady, 1);
        chk("rst_valid", b8.oValid, 0);
        chk("rst_busy", busyA, 0);
        chk("rst_data", b8.oData, 0);
        chk("rst_start", {startCa, startDa}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);

        // Abort mid-load with an asynchronous reset.
        for (int i = 0; i < 5; i++) begin
            b8.iData = 8'hA5; b8.iValid = 1'b1; b8.iMode = '0;
            @(negedge clk);
        end
        b8.iValid = 1'b0;
        chk("midload_v0", v0a, 32'h000000A5);
        chk("midload_v1", v1a, 32'hA5A5A5A5);
        chk("midload_busy", busyA, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", b8.oReady, 1);
        chk("arst_busy", busyA, 0);
        chk("arst_v0", v0a, 0);
        chk("arst_v1", v1a, 0);
        chk("arst_k", {k0a, k1a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        baseC = nStartC; baseD = nStartD;
        repeat (30) @(negedge clk);
        chk("arst_no_start", nStartC - baseC + nStartD - baseD, 0);
        chk("arst_no_valid", b8.oValid, 0);

        // Known-answer cipher on a zero block and zero key.
        baseC = nStartC;
        load8(192'h0, 24, 2'b00);
        chk("kat_startC", startCa, 1);
        chk("kat_startD", startDa, 0);
        chk("kat_start_ready", b8.oReady, 0);
        finish8(1'b0);
        unload8(KAT, 16'hFFFF);
        chk("kat_one_pulse", nStartC - baseC, 1);

        // Decipher of the KAT ciphertext under the zero key.
        baseC = nStartC; baseD = nStartD;
        load8({KAT, 128'h0}, 24, 2'b01);
        chk("dec_startD", startDa, 1);
        chk("dec_startC", startCa, 0);
        chk("dec_v0", v0a, KAT[63:32]);
        chk("dec_v1", v1a, KAT[31:0]);
        chk("dec_k0", k0a, 0);
        finish8(1'b1);
        unload8(64'h0, 16'hFFFF);
        chk("dec_no_cipher", nStartC - baseC, 0);
        chk("dec_one_pulse", nStartD - baseD, 1);

        // Distinct words check the word/slice ordering; output under backpressure.
        load8({32'h00112233, 32'h44556677, 32'h01234567, 32'h89ABCDEF,
               32'hFEDCBA98, 32'h76543210}, 24, 2'b00);
        chk("ord_v0", v0a, 32'h00112233);
        chk("ord_v1", v1a, 32'h44556677);
        chk("ord_k0", k0a, 32'h01234567);
        chk("ord_k1", k1a, 32'h89ABCDEF);
        chk("ord_k2", k2a, 32'hFEDCBA98);
        chk("ord_k3", k3a, 32'h76543210);
        finish8(1'b0);
        unload8(KAT, 16'b1011_0010_0110_1001);

`ifdef TEA_KEY_RETAIN_EN
        // Keep-key job: only V0,V1 are loaded; K0..K3 persist.
        load8({64'h0, 128'h0}, 8, 2'b10);
        chk("keep_start", startCa, 1);
        chk("keep_v0", v0a, 0);
        chk("keep_k0", k0a, 32'h01234567);
        chk("keep_k3", k3a, 32'h76543210);
        finish8(1'b0);
        unload8(KAT, 16'hFFFF);
`endif

        // 32-bit port: 6 load beats, 2 output beats.
        for (int i = 0; i < 6; i++) begin
            b32.iData = '0; b32.iValid = 1'b1; b32.iMode = '0;
            chk("w32_ready", b32.oReady, 1);
            @(negedge clk);
        end
        b32.iValid = 1'b0;
        chk("w32_start", startCb, 1);
        @(negedge clk);
        doneCb = 1'b1;
        @(negedge clk);
        doneCb = 1'b0;
        b32.iReady = 1'b1;
        chk("w32_valid0", b32.oValid, 1);
        chk("w32_beat0", b32.oData, KAT[63:32]);
        @(negedge clk);
        chk("w32_valid1", b32.oValid, 1);
        chk("w32_beat1", b32.oData, KAT[31:0]);
        @(negedge clk);
        b32.iReady = 1'b0;
        chk("w32_done", b32.oValid, 0);
        chk("w32_ready_after", b32.oReady, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
